spi_rom_responder: RTL

- Synthesizable SPI flash-ROM responder: the device end of the READ (03h) link driven by the VGA SPI ROM streamer.
- Used on-chip and in simulation as a stand-in flash so the streamer can be exercised without an external part.
- Oversamples SPI pins on the system clock, decodes 8-bit command + 24-bit address, then streams memory bytes MSB-first on MISO.
- Memory contents are loaded through a synchronous write port.

---
 rtl/spi_rom_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/spi_rom_responder.sv
// SPI flash-ROM responder for READ (03h): oversamples the SPI pins on clk,
// decodes opcode + 24-bit address, then streams memory bytes MSB-first on MISO.
module spi_rom_responder #(
  parameter int          ADDR_BITS = 8,
  parameter logic [7:0]  READ_CMD  = 8'h03
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_cs,
  input  logic                 spi_sclk,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  output logic                 busy,
  output logic                 bad_cmd,
  output logic [2:0]           state_dbg
);

  // Handshake: none; SPI edges are recovered from oversampled pins, the write
  // port is a plain strobe (wr_en high for one clk writes one byte).
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_IGNORE = 3'd4;

  logic [7:0] mem [2**ADDR_BITS];

  logic cs_s1, cs_s2, cs_d;
  logic sclk_s1, sclk_s2, sclk_d;
  logic mosi_s1, mosi_s2;

  logic [2:0]           state;
  logic [4:0]           bit_cnt;
  logic [7:0]           cmd_sr;
  logic [ADDR_BITS-1:0] addr_sr;
  logic [ADDR_BITS-1:0] ptr;
  logic [7:0]           data_sr;
  logic                 oe;
  logic                 lead_fall;

  logic                 rise, fall, cs_rise;
  logic [7:0]           cmd_next;
  logic [ADDR_BITS-1:0] addr_next;
  logic [ADDR_BITS-1:0] ptr_next;

  // cs chain presets high so a cs held high across reset is not seen as a new select
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      cs_s1   <= spi_cs;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      sclk_s1 <= spi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign rise      = cs_s2 & sclk_s2 & ~sclk_d;
  assign fall      = cs_s2 & ~sclk_s2 & sclk_d;
  assign cs_rise   = cs_s2 & ~cs_d;
  assign cmd_next  = {cmd_sr[6:0], mosi_s2};
  // Only the low ADDR_BITS of the 24-bit address matter; higher bits shift out.
  assign addr_next = {addr_sr[ADDR_BITS-2:0], mosi_s2};
  assign ptr_next  = ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= 5'd0;
      cmd_sr    <= 8'd0;
      addr_sr   <= '0;
      ptr       <= '0;
      data_sr   <= 8'd0;
      oe        <= 1'b0;
      lead_fall <= 1'b0;
      bad_cmd   <= 1'b0;
    end else begin
      bad_cmd <= 1'b0;
      if (!cs_s2) begin
        state     <= ST_IDLE;
        oe        <= 1'b0;
        lead_fall <= 1'b0;
        bit_cnt   <= 5'd0;
      end else begin
        case (state)
          ST_IDLE: if (cs_rise) begin
            state   <= ST_CMD;
            bit_cnt <= 5'd0;
          end
          ST_CMD: if (rise) begin
            cmd_sr  <= cmd_next;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= 5'd0;
              if (cmd_next == READ_CMD) begin
                state <= ST_ADDR;
              end else begin
                bad_cmd <= 1'b1;
                state   <= ST_IGNORE;
              end
            end
          end
          ST_ADDR: if (rise) begin
            addr_sr <= addr_next;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd23) begin
              bit_cnt   <= 5'd0;
              ptr       <= addr_next;
              data_sr   <= mem[addr_next];
              oe        <= 1'b1;
              lead_fall <= 1'b1;
              state     <= ST_DATA;
            end
          end
          ST_DATA: if (fall) begin
            // The trailing edge of the last address bit must leave bit 7 on the line.
            if (lead_fall) begin
              lead_fall <= 1'b0;
            end else if (bit_cnt == 5'd7) begin
              bit_cnt <= 5'd0;
              ptr     <= ptr_next;
              data_sr <= mem[ptr_next];
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              data_sr <= {data_sr[6:0], 1'b0};
            end
          end
          ST_IGNORE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign spi_miso    = oe & data_sr[7];
  assign spi_miso_oe = oe;
  assign busy        = (state != ST_IDLE);
  assign state_dbg   = state;

endmodule
